// File: rtl/servo_pwm_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// servo_pwm_driver : width command -> hobby-servo PWM for a fixed travel time.
//                    Define SERVO_HOLD_EN to keep pulsing at the last width in IDLE.
// Revision 1.0
// ============================================================================
module servo_pwm_driver #(
   parameter int TICK_DIV  = 50,
   parameter int PERIOD_US = 16384,
   parameter int TRAVEL_US = 250000,
   parameter int WIDTH_MIN = 500,
   parameter int WIDTH_MAX = 2500
) (
   input  logic        clk_50m,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [11:0] cmd_width,
   output logic        servo,
   output logic        busy,
   output logic        done
);

   localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PCW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
   localparam int TCW = $clog2(TRAVEL_US + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVING = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t         state, state_n;
   logic [PSW-1:0] presc, presc_n;
   logic [PCW-1:0] pcnt, pcnt_n;
   logic [TCW-1:0] tcnt, tcnt_n;
   logic [11:0]    width, width_n, clamped;
   logic           servo_n, done_n;
   logic           tick, run, start, in_pulse, pulse_n;

   always_comb begin
      if (cmd_width < 12'(WIDTH_MIN))
         clamped = 12'(WIDTH_MIN);
      else if (cmd_width > 12'(WIDTH_MAX))
         clamped = 12'(WIDTH_MAX);
      else
         clamped = cmd_width;
   end

   // In IDLE a held pulse must finish before a new command restarts the period.
   assign cmd_ready = (state == IDLE) && !servo;
   assign busy      = (state != IDLE);

   always_comb begin
      state_n = state;
      presc_n = presc;
      pcnt_n  = pcnt;
      tcnt_n  = tcnt;
      width_n = width;
      servo_n = 1'b0;
      done_n  = 1'b0;
      tick    = (presc == PSW'(TICK_DIV - 1));
`ifdef SERVO_HOLD_EN
      run     = 1'b1;
`else
      run     = (state != IDLE);
`endif
      if (run) begin
         if (tick) begin
            presc_n = '0;
            pcnt_n  = (pcnt == PCW'(PERIOD_US - 1)) ? '0 : pcnt + 1'b1;
         end else begin
            presc_n = presc + 1'b1;
         end
      end
      if ((state == MOVING) && tick && (tcnt != TCW'(TRAVEL_US)))
         tcnt_n = tcnt + 1'b1;

      // Pulses only start on a period boundary, so a late start never yields a runt.
      start    = (presc_n == '0) && (pcnt_n == '0) && (width != '0);
      in_pulse = servo && (32'(pcnt_n) < 32'(width));
      pulse_n  = start || in_pulse;

      case (state)
         IDLE: begin
`ifdef SERVO_HOLD_EN
            servo_n = pulse_n;
`endif
            if (cmd_valid && cmd_ready) begin
               width_n = clamped;
               presc_n = '0;
               pcnt_n  = '0;
               tcnt_n  = '0;
               servo_n = 1'b1;
               state_n = MOVING;
            end
         end
         MOVING: begin
            if (tcnt_n == TCW'(TRAVEL_US)) begin
               if (in_pulse) begin
                  servo_n = 1'b1;
                  state_n = DRAIN;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               servo_n = pulse_n;
            end
         end
         DRAIN: begin
            servo_n = in_pulse;
            if (!in_pulse) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state <= IDLE;
         presc <= '0;
         pcnt  <= '0;
         tcnt  <= '0;
         width <= '0;
         servo <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         presc <= presc_n;
         pcnt  <= pcnt_n;
         tcnt  <= tcnt_n;
         width <= width_n;
         servo <= servo_n;
         done  <= done_n;
      end
   end

endmodule
`default_nettype wire
